// File: rtl/bram_access_ctrl_if.sv
// CPU-side request/response and RAM-side port bundle for bram_access_ctrl.
// The master is the CPU plus the RAM model, and the slave is the access controller.
interface bram_access_ctrl_if #(
  parameter int ADDRESS_BITWIDTH = 16,
  parameter int DATA_BITWIDTH    = 32
);
  logic                          enable;
  logic [1:0]                    write_type;
  logic [2:0]                    read_type;
  logic [ADDRESS_BITWIDTH-1:0]   address;
  logic [DATA_BITWIDTH-1:0]      data_in;
  logic [DATA_BITWIDTH-1:0]      data_out;
  logic                          done;
  logic                          busy;
  logic                          error;
  logic [ADDRESS_BITWIDTH-3:0]   ram_address;
  logic [DATA_BITWIDTH/8-1:0]    ram_write_enable;
  logic [DATA_BITWIDTH-1:0]      ram_data_in;
  logic [DATA_BITWIDTH-1:0]      ram_data_out;

  modport master (
    output enable, write_type, read_type, address, data_in, ram_data_out,
    input  data_out, done, busy, error, ram_address, ram_write_enable, ram_data_in
  );

  modport slave (
    input  enable, write_type, read_type, address, data_in, ram_data_out,
    output data_out, done, busy, error, ram_address, ram_write_enable, ram_data_in
  );
endinterface

// File: rtl/bram_access_ctrl.sv
// Byte/half/word load-store front end for a byte-enabled block RAM; word-crossing accesses split into two RAM cycles.
// Optional macro BRAM_ACCESS_MISALIGNED_TRAP_EN turns crossing accesses into an error pulse instead of a split.
module bram_access_ctrl #(
  parameter int ADDRESS_BITWIDTH = 16,
  parameter int DATA_BITWIDTH    = 32
) (
  input logic              clk,
  input logic              rst,
  bram_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_e;

  state_e                        state_q, state_d;
  logic                          isWrite_q;
  logic                          isSigned_q;
  logic [1:0]                    sizeCode_q;
  logic [1:0]                    offset_q;
  logic [ADDRESS_BITWIDTH-3:0]   word_q;
  logic [DATA_BITWIDTH-1:0]      wdata_q;
  logic [DATA_BITWIDTH-1:0]      firstWord_q;
  logic [DATA_BITWIDTH-1:0]      dataOut_q;

  logic                          accept_w;
  logic [2:0]                    sizeBytes_w;
  logic [3:0]                    sizeMask_w;
  logic                          cross_w;
  logic                          trap_w;
  logic [7:0]                    laneMask_w;
  logic [2*DATA_BITWIDTH-1:0]    wdataShift_w;
  logic [2*DATA_BITWIDTH-1:0]    rawSource_w;
  logic [DATA_BITWIDTH-1:0]      loadRaw_w;
  logic [DATA_BITWIDTH-1:0]      loadExt_w;
  logic                          loadFinish_w;

  // Entering DONE counts as not busy, so a request can follow straight on from it.
  assign accept_w = bus.enable && (state_q == IDLE || state_q == DONE) &&
                    (bus.write_type != 2'b00 || bus.read_type != 3'b000);

  always_comb begin
    sizeBytes_w = 3'd1;
    sizeMask_w  = 4'b0001;
    case (sizeCode_q)
      2'b10: begin sizeBytes_w = 3'd2; sizeMask_w = 4'b0011; end
      2'b11: begin sizeBytes_w = 3'd4; sizeMask_w = 4'b1111; end
      default: begin sizeBytes_w = 3'd1; sizeMask_w = 4'b0001; end
    endcase
  end

  assign cross_w      = ({2'b00, offset_q} + {1'b0, sizeBytes_w}) > 4'd4;
  assign laneMask_w   = {4'b0000, sizeMask_w} << offset_q;
  assign wdataShift_w = {{DATA_BITWIDTH{1'b0}}, wdata_q} << {offset_q, 3'b000};

`ifdef BRAM_ACCESS_MISALIGNED_TRAP_EN
  assign trap_w = cross_w;
`else
  assign trap_w = 1'b0;
`endif

  // In SECOND the live RAM word supplies the bytes above those captured in FIRST.
  assign rawSource_w = (state_q == SECOND) ? {bus.ram_data_out, firstWord_q}
                                           : {{DATA_BITWIDTH{1'b0}}, bus.ram_data_out};
  assign loadRaw_w   = DATA_BITWIDTH'(rawSource_w >> {offset_q, 3'b000});

  always_comb begin
    loadExt_w = loadRaw_w;
    case (sizeCode_q)
      2'b10: loadExt_w = isSigned_q ? {{(DATA_BITWIDTH-16){loadRaw_w[15]}}, loadRaw_w[15:0]}
                                    : {{(DATA_BITWIDTH-16){1'b0}}, loadRaw_w[15:0]};
      2'b11: loadExt_w = loadRaw_w;
      default: loadExt_w = isSigned_q ? {{(DATA_BITWIDTH-8){loadRaw_w[7]}}, loadRaw_w[7:0]}
                                      : {{(DATA_BITWIDTH-8){1'b0}}, loadRaw_w[7:0]};
    endcase
  end

  assign loadFinish_w = !isWrite_q &&
                        ((state_q == FIRST && !cross_w) || state_q == SECOND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      isWrite_q   <= 1'b0;
      isSigned_q  <= 1'b0;
      sizeCode_q  <= 2'b00;
      offset_q    <= 2'b00;
      word_q      <= '0;
      wdata_q     <= '0;
      firstWord_q <= '0;
      dataOut_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept_w) begin
        offset_q <= bus.address[1:0];
        word_q   <= bus.address[ADDRESS_BITWIDTH-1:2];
        wdata_q  <= bus.data_in;
        if (bus.write_type != 2'b00) begin
          isWrite_q  <= 1'b1;
          isSigned_q <= 1'b0;
          sizeCode_q <= bus.write_type;
        end else begin
          isWrite_q  <= 1'b0;
          isSigned_q <= bus.read_type[2];
          sizeCode_q <= bus.read_type[1:0];
        end
      end
      if (state_q == FIRST) firstWord_q <= bus.ram_data_out;
      if (loadFinish_w) dataOut_q <= loadExt_w;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_w) state_d = FIRST;
      FIRST:   state_d = (cross_w && !trap_w) ? SECOND : DONE;
      SECOND:  state_d = DONE;
      DONE:    state_d = accept_w ? FIRST : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write enables are gated by rst so a reset in FIRST/SECOND never lands a write.
  always_comb begin
    bus.ram_address      = '0;
    bus.ram_write_enable = '0;
    bus.ram_data_in      = '0;
    case (state_q)
      FIRST: begin
        bus.ram_address = word_q;
        bus.ram_data_in = wdataShift_w[DATA_BITWIDTH-1:0];
        if (isWrite_q && !trap_w) bus.ram_write_enable = laneMask_w[3:0];
      end
      SECOND: begin
        bus.ram_address = word_q + 1'b1;
        bus.ram_data_in = wdataShift_w[2*DATA_BITWIDTH-1:DATA_BITWIDTH];
        if (isWrite_q) bus.ram_write_enable = laneMask_w[7:4];
      end
      default: ;
    endcase
    if (rst) bus.ram_write_enable = '0;
  end

  assign bus.done     = (state_q == DONE);
  assign bus.busy     = (state_q == FIRST) || (state_q == SECOND);
  assign bus.error    = (state_q == DONE) && trap_w;
  assign bus.data_out = dataOut_q;

endmodule

// File: tb/tb_bram_access_ctrl.sv
// Directed bench for bram_access_ctrl: a behavioural byte-enabled RAM plus hand-computed expectations.
module tb_bram_access_ctrl;

  localparam int AW = 16;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   passCount;
  int   checkCount;
  int   weCount;
  int   weSnapshot;
  logic [DW-1:0] mem [0:(1<<(AW-2))-1];

  bram_access_ctrl_if #(.ADDRESS_BITWIDTH(AW), .DATA_BITWIDTH(DW)) bus ();

  bram_access_ctrl #(.ADDRESS_BITWIDTH(AW), .DATA_BITWIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Semi-dual-port RAM: combinational read, byte-enabled synchronous write.
  assign bus.ram_data_out = mem[bus.ram_address];
  always @(posedge clk) begin
    if (bus.ram_write_enable != 4'b0000) weCount <= weCount + 1;
    for (int i = 0; i < 4; i++)
      if (bus.ram_write_enable[i]) mem[bus.ram_address][8*i +: 8] <= bus.ram_data_in[8*i +: 8];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount = checkCount + 1;
    assert (observed === expected) passCount = passCount + 1;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Presents one request for a single edge; returns #1 after the accept edge (controller in FIRST).
  task automatic applyStimulus(input logic [1:0] wt, input logic [2:0] rt,
                               input logic [AW-1:0] addr, input logic [31:0] din);
    @(negedge clk);
    bus.enable     = 1'b1;
    bus.write_type = wt;
    bus.read_type  = rt;
    bus.address    = addr;
    bus.data_in    = din;
    @(posedge clk);
    #1;
    bus.enable     = 1'b0;
    bus.write_type = 2'b00;
    bus.read_type  = 3'b000;
    bus.address    = '0;
    bus.data_in    = '0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passCount      = 0;
    checkCount     = 0;
    weCount        = 0;
    rst            = 1'b1;
    bus.enable     = 1'b0;
    bus.write_type = 2'b00;
    bus.read_type  = 3'b000;
    bus.address    = '0;
    bus.data_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_data_out", bus.data_out, 32'h0);
    checkOutput("rst_done", {31'b0, bus.done}, 32'h0);
    checkOutput("rst_busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("rst_error", {31'b0, bus.error}, 32'h0);
    checkOutput("rst_we", {28'b0, bus.ram_write_enable}, 32'h0);
    checkOutput("rst_addr", {18'b0, bus.ram_address}, 32'h0);
    rst = 1'b0;

    // Request with both types zero must be ignored.
    applyStimulus(2'b00, 3'b000, 16'h0010, 32'h0);
    checkOutput("idle_ignore_busy", {31'b0, bus.busy}, 32'h0);

    // Word store 0xDEADBEEF @0x0010.
    applyStimulus(2'b11, 3'b000, 16'h0010, 32'hDEADBEEF);
    checkOutput("sw_busy", {31'b0, bus.busy}, 32'h1);
    checkOutput("sw_done_first", {31'b0, bus.done}, 32'h0);
    checkOutput("sw_addr", {18'b0, bus.ram_address}, 32'h4);
    checkOutput("sw_we", {28'b0, bus.ram_write_enable}, 32'hF);
    checkOutput("sw_wdata", bus.ram_data_in, 32'hDEADBEEF);
    nextCycle();
    checkOutput("sw_done", {31'b0, bus.done}, 32'h1);
    checkOutput("sw_busy_done", {31'b0, bus.busy}, 32'h0);

    // Word load @0x0010, accepted back-to-back while done=1.
    applyStimulus(2'b00, 3'b011, 16'h0010, 32'h0);
    checkOutput("lw_we", {28'b0, bus.ram_write_enable}, 32'h0);
    checkOutput("lw_addr", {18'b0, bus.ram_address}, 32'h4);
    nextCycle();
    checkOutput("lw_done", {31'b0, bus.done}, 32'h1);
    checkOutput("lw_data", bus.data_out, 32'hDEADBEEF);

    // Byte store 0x80 @0x0013 then signed and unsigned byte loads.
    applyStimulus(2'b01, 3'b000, 16'h0013, 32'h00000080);
    checkOutput("sb_we", {28'b0, bus.ram_write_enable}, 32'h8);
    checkOutput("sb_lane3", {24'b0, bus.ram_data_in[31:24]}, 32'h80);
    nextCycle();
    applyStimulus(2'b00, 3'b101, 16'h0013, 32'h0);
    nextCycle();
    checkOutput("lbs_data", bus.data_out, 32'hFFFFFF80);
    applyStimulus(2'b00, 3'b001, 16'h0013, 32'h0);
    nextCycle();
    checkOutput("lbu_data", bus.data_out, 32'h00000080);
    applyStimulus(2'b00, 3'b010, 16'h0012, 32'h0);
    nextCycle();
    checkOutput("lhu_data", bus.data_out, 32'h000080AD);

    // Write wins over read when both types are set.
    applyStimulus(2'b01, 3'b011, 16'h0020, 32'h0000005A);
    checkOutput("both_we", {28'b0, bus.ram_write_enable}, 32'h1);
    nextCycle();
    checkOutput("both_done", {31'b0, bus.done}, 32'h1);
    checkOutput("both_data_hold", bus.data_out, 32'h000080AD);

`ifndef BRAM_ACCESS_MISALIGNED_TRAP_EN
    // Half store 0xA1B2 @0x0003 crosses into word 1.
    applyStimulus(2'b10, 3'b000, 16'h0003, 32'h0000A1B2);
    checkOutput("sh_x_addr1", {18'b0, bus.ram_address}, 32'h0);
    checkOutput("sh_x_we1", {28'b0, bus.ram_write_enable}, 32'h8);
    checkOutput("sh_x_lane3", {24'b0, bus.ram_data_in[31:24]}, 32'hB2);
    nextCycle();
    checkOutput("sh_x_addr2", {18'b0, bus.ram_address}, 32'h1);
    checkOutput("sh_x_we2", {28'b0, bus.ram_write_enable}, 32'h1);
    checkOutput("sh_x_lane0", {24'b0, bus.ram_data_in[7:0]}, 32'hA1);
    checkOutput("sh_x_busy2", {31'b0, bus.busy}, 32'h1);
    checkOutput("sh_x_done2", {31'b0, bus.done}, 32'h0);
    nextCycle();
    checkOutput("sh_x_done", {31'b0, bus.done}, 32'h1);

    applyStimulus(2'b00, 3'b110, 16'h0003, 32'h0);
    nextCycle();
    checkOutput("lhs_x_done_early", {31'b0, bus.done}, 32'h0);
    nextCycle();
    checkOutput("lhs_x_done", {31'b0, bus.done}, 32'h1);
    checkOutput("lhs_x_data", bus.data_out, 32'hFFFFA1B2);

    // Word store @0xFFFE wraps the second half to word 0.
    applyStimulus(2'b11, 3'b000, 16'hFFFE, 32'h11223344);
    checkOutput("sw_wrap_addr1", {18'b0, bus.ram_address}, 32'h3FFF);
    checkOutput("sw_wrap_we1", {28'b0, bus.ram_write_enable}, 32'hC);
    checkOutput("sw_wrap_hi1", {16'b0, bus.ram_data_in[31:16]}, 32'h3344);
    nextCycle();
    checkOutput("sw_wrap_addr2", {18'b0, bus.ram_address}, 32'h0);
    checkOutput("sw_wrap_we2", {28'b0, bus.ram_write_enable}, 32'h3);
    checkOutput("sw_wrap_lo2", {16'b0, bus.ram_data_in[15:0]}, 32'h1122);
    nextCycle();
    applyStimulus(2'b00, 3'b011, 16'hFFFE, 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("lw_wrap_data", bus.data_out, 32'h11223344);

    // Reset during FIRST of a crossing word store.
    applyStimulus(2'b11, 3'b000, 16'h0005, 32'h55667788);
    weSnapshot = weCount;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_we_now", {28'b0, bus.ram_write_enable}, 32'h0);
    nextCycle();
    rst = 1'b0;
    checkOutput("rstmid_busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("rstmid_done", {31'b0, bus.done}, 32'h0);
    nextCycle();
    checkOutput("rstmid_done_late", {31'b0, bus.done}, 32'h0);
    checkOutput("rstmid_we_count", weCount, weSnapshot);
    applyStimulus(2'b00, 3'b110, 16'h0003, 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("rstmid_next_done", {31'b0, bus.done}, 32'h1);
    checkOutput("rstmid_next_data", bus.data_out, 32'hFFFFA1B2);
`else
    // Trap build: crossing accesses report error and leave RAM and data_out alone.
    applyStimulus(2'b00, 3'b011, 16'h0001, 32'h0);
    checkOutput("trap_ld_we", {28'b0, bus.ram_write_enable}, 32'h0);
    nextCycle();
    checkOutput("trap_ld_done", {31'b0, bus.done}, 32'h1);
    checkOutput("trap_ld_error", {31'b0, bus.error}, 32'h1);
    checkOutput("trap_ld_data", bus.data_out, 32'h000080AD);
    weSnapshot = weCount;
    applyStimulus(2'b11, 3'b000, 16'h0011, 32'h12345678);
    checkOutput("trap_st_we", {28'b0, bus.ram_write_enable}, 32'h0);
    nextCycle();
    checkOutput("trap_st_error", {31'b0, bus.error}, 32'h1);
    checkOutput("trap_st_we_count", weCount, weSnapshot);
    applyStimulus(2'b00, 3'b011, 16'h0010, 32'h0);
    nextCycle();
    checkOutput("trap_aligned_error", {31'b0, bus.error}, 32'h0);
    checkOutput("trap_aligned_data", bus.data_out, 32'h80ADBEEF);
`endif

    nextCycle();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
